control_unit_pipe: RTL

CONTROL_UNIT_PIPE -- requirements
Module: control_unit_pipe

---
 rtl/control_pkg.sv | 50 +++++
 rtl/ctrl_decode.sv | 127 ++++++++++++
 rtl/control_unit_pipe.sv | 94 +++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared control definitions: opcodes, ALU operation codes, ALUControl and
// ResultSrc encodings, immediate selects and the per-stage control bundle.
package control_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [3:0] alu_control;
  } ctrl_bundle_t;

  localparam int CTRL_W = $bits(ctrl_bundle_t);
  localparam ctrl_bundle_t BUBBLE = ctrl_bundle_t'(12'h000);

endpackage

// File: rtl/ctrl_decode.sv
// Combinational main + ALU decoder producing the Decode-stage control bundle.
module ctrl_decode
  import control_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int EXT_OPS    = 0,
  parameter int JUMP_EN    = 1
) (
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  output logic [CTRL_W-1:0] bundle,
  output logic [1:0]        imm_src,
  output logic              illegal
);

  // Extended ops need the 4-bit ALUControl encoding to be representable.
  localparam logic EXT_EN = (EXT_OPS == 1) && (ALU_CTRL_W == 4);

  ctrl_bundle_t main_s;
  ctrl_bundle_t out_s;
  logic [1:0]   aluop_s;
  logic         is_r_s;
  logic [3:0]   alu_ctrl_s;
  logic         unused_s;

  // Main decoder: opcode to control fields, immediate select and legality.
  always_comb begin
    main_s  = BUBBLE;
    aluop_s = ALUOP_ADD;
    is_r_s  = 1'b0;
    imm_src = IMM_I;
    illegal = 1'b0;
    case (op)
      OP_LW: begin
        main_s.valid      = 1'b1;
        main_s.reg_write  = 1'b1;
        main_s.result_src = RES_MEM;
        main_s.alu_src    = 1'b1;
      end
      OP_SW: begin
        main_s.valid     = 1'b1;
        main_s.mem_write = 1'b1;
        main_s.alu_src   = 1'b1;
        imm_src          = IMM_S;
      end
      OP_R: begin
        main_s.valid     = 1'b1;
        main_s.reg_write = 1'b1;
        aluop_s          = ALUOP_FUNCT;
        is_r_s           = 1'b1;
      end
      OP_I: begin
        main_s.valid     = 1'b1;
        main_s.reg_write = 1'b1;
        main_s.alu_src   = 1'b1;
        aluop_s          = ALUOP_FUNCT;
      end
      OP_BEQ: begin
        main_s.valid  = 1'b1;
        main_s.branch = 1'b1;
        aluop_s       = ALUOP_SUB;
        imm_src       = IMM_B;
      end
      OP_JAL: begin
        if (JUMP_EN == 1) begin
          main_s.valid      = 1'b1;
          main_s.reg_write  = 1'b1;
          main_s.result_src = RES_PC4;
          main_s.jump       = 1'b1;
          imm_src           = IMM_J;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  // ALU decoder: only R-type may subtract; funct7[5] splits sra from srl.
  always_comb begin
    alu_ctrl_s = ALU_ADD;
    case (aluop_s)
      ALUOP_ADD: alu_ctrl_s = ALU_ADD;
      ALUOP_SUB: alu_ctrl_s = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if (is_r_s && funct7[5]) alu_ctrl_s = ALU_SUB;
            else                     alu_ctrl_s = ALU_ADD;
          end
          3'b010: alu_ctrl_s = ALU_SLT;
          3'b110: alu_ctrl_s = ALU_OR;
          3'b111: alu_ctrl_s = ALU_AND;
          3'b100: begin
            if (EXT_EN) alu_ctrl_s = ALU_XOR;
            else        alu_ctrl_s = ALU_ADD;
          end
          3'b001: begin
            if (EXT_EN) alu_ctrl_s = ALU_SLL;
            else        alu_ctrl_s = ALU_ADD;
          end
          3'b101: begin
            if (EXT_EN) alu_ctrl_s = funct7[5] ? ALU_SRA : ALU_SRL;
            else        alu_ctrl_s = ALU_ADD;
          end
          3'b011: begin
            if (EXT_EN) alu_ctrl_s = ALU_SLTU;
            else        alu_ctrl_s = ALU_ADD;
          end
          default: alu_ctrl_s = ALU_ADD;
        endcase
      end
      default: alu_ctrl_s = ALU_ADD;
    endcase
  end

  // Merge ALU selection into the main bundle.
  always_comb begin
    out_s             = main_s;
    out_s.alu_control = alu_ctrl_s;
  end

  assign bundle   = out_s;
  assign unused_s = ^{funct7[6], funct7[4:0]};

endmodule

// File: rtl/control_unit_pipe.sv
// Pipelined control unit: decodes in D and carries control through E, M, W.
module control_unit_pipe
  import control_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int EXT_OPS    = 0,
  parameter int JUMP_EN    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            Op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  ZeroE,
  output logic [1:0]            ImmSrcD,
  output logic                  IllegalD,
  output logic                  RegWriteE,
  output logic                  RegWriteM,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcE,
  output logic [1:0]            ResultSrcM,
  output logic [1:0]            ResultSrcW,
  output logic                  MemWriteE,
  output logic                  MemWriteM,
  output logic                  ALUSrcE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  PCSrcE,
  output logic                  ValidW
);

  logic [CTRL_W-1:0] dec_bits_s;
  ctrl_bundle_t      dec_s;
  ctrl_bundle_t      e_r;
  ctrl_bundle_t      m_r;
  ctrl_bundle_t      w_r;
  logic              stall_only_s;
  logic              unused_s;

  ctrl_decode #(
    .ALU_CTRL_W(ALU_CTRL_W),
    .EXT_OPS   (EXT_OPS),
    .JUMP_EN   (JUMP_EN)
  ) u_decode (
    .op     (Op),
    .funct3 (funct3),
    .funct7 (funct7),
    .bundle (dec_bits_s),
    .imm_src(ImmSrcD),
    .illegal(IllegalD)
  );

  assign dec_s = ctrl_bundle_t'(dec_bits_s);
  // A flush overrides the stall, so M only sees a bubble for a pure stall.
  assign stall_only_s = StallE & ~FlushE;

  // Execute register: flush beats stall, stall holds, otherwise capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         e_r <= BUBBLE;
    else if (FlushE) e_r <= BUBBLE;
    else if (StallE) e_r <= e_r;
    else             e_r <= dec_s;
  end

  // Memory and Writeback registers advance every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_r <= BUBBLE;
      w_r <= BUBBLE;
    end else begin
      m_r <= stall_only_s ? BUBBLE : e_r;
      w_r <= m_r;
    end
  end

  assign RegWriteE   = e_r.reg_write;
  assign RegWriteM   = m_r.reg_write;
  assign RegWriteW   = w_r.reg_write;
  assign ResultSrcE  = e_r.result_src;
  assign ResultSrcM  = m_r.result_src;
  assign ResultSrcW  = w_r.result_src;
  assign MemWriteE   = e_r.mem_write;
  assign MemWriteM   = m_r.mem_write;
  assign ALUSrcE     = e_r.alu_src;
  assign ALUControlE = e_r.alu_control[ALU_CTRL_W-1:0];
  assign ValidW      = w_r.valid;
  assign PCSrcE      = (e_r.branch & ZeroE) | e_r.jump;

  assign unused_s = ^{e_r.alu_control[3], m_r.alu_control, m_r.alu_src, m_r.branch,
                      m_r.jump, w_r.mem_write, w_r.alu_src, w_r.branch, w_r.jump,
                      w_r.alu_control};

endmodule
